// File: rtl/wb_pkg.sv
// Shared types for the functional-unit writeback collector.
//
// wb_pkt_t carries one FU result: ROB uid, 16-bit value and 18-bit destination
// location. The ROB uid width comes from the ROB_QUEUE_BITS macro. If the
// surrounding core has not defined it, a default is supplied here.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 6
`endif

package wb_pkg;

    localparam int WB_UID_W = `ROB_QUEUE_BITS;
    localparam int WB_VAL_W = 16;
    localparam int WB_LOC_W = 18;

    typedef struct packed {
        logic [`ROB_QUEUE_BITS-1:0] uid;
        logic [15:0]                val;
        logic [17:0]                loc;
    } wb_pkt_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: one DEPTH-entry result buffer for a single functional unit.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset (empties the buffer)
//   push      : write wr_pkt at the tail (ignored when full)
//   pop       : advance the head (ignored when empty)
//   wr_pkt    : packet to write
//   head      : oldest entry, combinational from registered state
//   count     : number of valid entries, 0..DEPTH
//
// DEPTH must be a power of two so the read and write pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_pkt_t                  wr_pkt,
    output wb_pkt_t                  head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_pkt_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count_reg != FULL_CNT);
    assign do_pop  = pop && (count_reg != '0);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fu_wb_collector.sv
// fu_wb_collector: gathers results from NUM_FU functional units into
// per-unit DEPTH-entry buffers and round-robin arbitrates them onto a single
// common data bus (CDB), one result per cycle.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   fu_valid[i]   : FU i presents a result (has_outgoing)
//   fu_uid/val/loc: per-FU packed result fields, FU i in slice i
//   fu_ready[i]   : buffer i can accept (registered count only, 0 in reset)
//   cdb_valid     : a result is on the CDB
//   cdb_uid/val/loc: CDB result fields (zero whenever cdb_valid is low)
//   cdb_grant     : source FU of the CDB result; holds last value when idle
//   cdb_ready     : consumer accepts the CDB result this cycle
//
// Optional build macro WB_BYPASS_EN: when every buffer is empty and no grant
// is held, a valid FU result goes straight to the CDB in the same cycle. If it
// is accepted, it is never written to its buffer.
module fu_wb_collector
    import wb_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*WB_UID_W-1:0]  fu_uid,
    input  logic [NUM_FU*WB_VAL_W-1:0]  fu_val,
    input  logic [NUM_FU*WB_LOC_W-1:0]  fu_loc,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic                        cdb_valid,
    output logic [WB_UID_W-1:0]         cdb_uid,
    output logic [WB_VAL_W-1:0]         cdb_val,
    output logic [WB_LOC_W-1:0]         cdb_loc,
    output logic [$clog2(NUM_FU)-1:0]   cdb_grant,
    input  logic                        cdb_ready
);

    localparam int GW = $clog2(NUM_FU);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] LAST_FU  = GW'(NUM_FU - 1);

    // First set bit of req scanning upward from ptr, modulo NUM_FU.
    // Returns {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [NUM_FU-1:0] req,
                                            input logic [GW-1:0]     ptr);
        logic [GW-1:0] idx;
        logic [GW:0]   res;
        res = '0;
        idx = ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!res[GW] && req[idx]) begin
                res = {1'b1, idx};
            end
            idx = (idx == LAST_FU) ? '0 : idx + 1'b1;
        end
        return res;
    endfunction

    wb_pkt_t           in_pkt   [NUM_FU];
    wb_pkt_t           head_pkt [NUM_FU];
    logic [CW-1:0]     count    [NUM_FU];
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;

    logic [GW-1:0]     rr_ptr_reg;
    logic [GW-1:0]     grant_reg;
    logic              lock_reg;      // previous cycle stalled: grant is frozen
    logic [GW:0]       scan_pick;
    logic              bypass;
    logic [GW-1:0]     byp_idx;
    logic              bypass_take;
    logic              cdb_take;
    wb_pkt_t           sel_pkt;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
            assign in_pkt[gi] = {fu_uid[gi*WB_UID_W +: WB_UID_W],
                                 fu_val[gi*WB_VAL_W +: WB_VAL_W],
                                 fu_loc[gi*WB_LOC_W +: WB_LOC_W]};

            assign nonempty[gi] = (count[gi] != '0);
            assign fu_ready[gi] = !rst && (count[gi] != FULL_CNT);

            // A bypassed packet that the CDB accepts never enters its buffer.
            assign push[gi] = fu_valid[gi] && fu_ready[gi] &&
                              !(bypass_take && (byp_idx == GW'(gi)));
            assign pop[gi]  = cdb_take && !bypass && (cdb_grant == GW'(gi));

            wb_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .push   (push[gi]),
                .pop    (pop[gi]),
                .wr_pkt (in_pkt[gi]),
                .head   (head_pkt[gi]),
                .count  (count[gi])
            );
        end
    endgenerate

    assign scan_pick = rr_pick(nonempty, rr_ptr_reg);

`ifdef WB_BYPASS_EN
    logic [GW:0] byp_pick;
    assign byp_pick = rr_pick(fu_valid, rr_ptr_reg);
    // lock_reg implies a non-empty buffer, so the empty test alone excludes it;
    // it is kept explicit for clarity.
    assign bypass   = !rst && !lock_reg && (nonempty == '0) && byp_pick[GW];
    assign byp_idx  = byp_pick[GW-1:0];
`else
    assign bypass   = 1'b0;
    assign byp_idx  = '0;
`endif

    assign bypass_take = bypass && cdb_ready;

    always_comb begin
        cdb_valid = 1'b0;
        cdb_grant = grant_reg;
        sel_pkt   = head_pkt[grant_reg];
        if (rst) begin
            cdb_grant = '0;
        end else if (lock_reg) begin
            // Stalled last cycle: keep the same source so a newly filled
            // buffer closer to the pointer cannot preempt it.
            cdb_valid = 1'b1;
        end else if (bypass) begin
            cdb_valid = 1'b1;
            cdb_grant = byp_idx;
            sel_pkt   = in_pkt[byp_idx];
        end else if (scan_pick[GW]) begin
            cdb_valid = 1'b1;
            cdb_grant = scan_pick[GW-1:0];
            sel_pkt   = head_pkt[scan_pick[GW-1:0]];
        end
        cdb_uid = cdb_valid ? sel_pkt.uid : '0;
        cdb_val = cdb_valid ? sel_pkt.val : '0;
        cdb_loc = cdb_valid ? sel_pkt.loc : '0;
    end

    assign cdb_take = cdb_valid && cdb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            lock_reg   <= 1'b0;
        end else begin
            grant_reg <= cdb_grant;
            lock_reg  <= cdb_valid && !cdb_ready;
            if (cdb_take) begin
                rr_ptr_reg <= (cdb_grant == LAST_FU) ? '0 : cdb_grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fu_wb_collector.sv
// Testbench for fu_wb_collector (NUM_FU=4, DEPTH=2). Expected CDB packets are
// queued in hand-derived order before stimulus; a negedge monitor pops and
// compares every accepted CDB transfer, checks stall stability and flags
// fu_valid asserted against a low fu_ready.
module tb_fu_wb_collector;
    import wb_pkg::*;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
    localparam int GW     = 2;
    localparam int UW     = WB_UID_W;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_FU-1:0]          fu_valid;
    logic [NUM_FU*UW-1:0]       fu_uid;
    logic [NUM_FU*WB_VAL_W-1:0] fu_val;
    logic [NUM_FU*WB_LOC_W-1:0] fu_loc;
    logic [NUM_FU-1:0]          fu_ready;
    logic                       cdb_valid;
    logic [UW-1:0]              cdb_uid;
    logic [WB_VAL_W-1:0]        cdb_val;
    logic [WB_LOC_W-1:0]        cdb_loc;
    logic [GW-1:0]              cdb_grant;
    logic                       cdb_ready;

    fu_wb_collector #(
        .NUM_FU (NUM_FU),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fu_valid  (fu_valid),
        .fu_uid    (fu_uid),
        .fu_val    (fu_val),
        .fu_loc    (fu_loc),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_uid   (cdb_uid),
        .cdb_val   (cdb_val),
        .cdb_loc   (cdb_loc),
        .cdb_grant (cdb_grant),
        .cdb_ready (cdb_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [UW-1:0]       uid;
        logic [WB_VAL_W-1:0] val;
        logic [WB_LOC_W-1:0] loc;
        logic [GW-1:0]       grant;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_pkt(input int fu, input int uid, input logic [15:0] val, input logic [17:0] loc);
        exp_t e;
        e.uid   = UW'(uid);
        e.val   = val;
        e.loc   = loc;
        e.grant = GW'(fu);
        exp_q.push_back(e);
    endtask

    task automatic issue(input int fu, input int uid, input logic [15:0] val, input logic [17:0] loc);
        fu_uid[fu*UW +: UW]             = UW'(uid);
        fu_val[fu*WB_VAL_W +: WB_VAL_W] = val;
        fu_loc[fu*WB_LOC_W +: WB_LOC_W] = loc;
        fu_valid[fu]                    = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Stream n packets from one FU, each issued only when fu_ready allows.
    // cdb_ready is raised at iteration release_it; FU3 gets one side packet
    // alongside packet side_k (side_k < 0: none).
    task automatic stream(input int fu, input int n, input int uid0, input int release_it, input int side_k);
        int k;
        int it;
        k  = 0;
        it = 0;
        while (k < n && it < 100) begin
            tick();
            fu_valid[3] = (fu == 3) ? fu_valid[3] : 1'b0;
            if (fu_ready[fu]) begin
                issue(fu, uid0 + k, 16'hA000 | 16'(k), 18'(fu * 256 + k));
                if (k == side_k) begin
                    issue(3, 50, 16'h0F03, 18'h00003);
                end
                k++;
            end else begin
                fu_valid[fu] = 1'b0;
            end
            if (it == release_it) begin
                cdb_ready = 1'b1;
            end
            it++;
        end
        check("stream_budget", 64'(k), 64'(n));
        tick();
        fu_valid = '0;
    endtask

    // Monitor: scoreboard compare, stall stability, protocol.
    logic          prev_stall = 1'b0;
    logic [42:0]   prev_out;
    exp_t          e_mon;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {cdb_uid, cdb_val, cdb_loc, cdb_grant, cdb_valid}, prev_out);
            end
            if (cdb_valid && cdb_ready) begin
                n_txn++;
                $display("cdb txn %0d: grant=%0d uid=%0d val=%04h loc=%05h",
                         n_txn, cdb_grant, cdb_uid, cdb_val, cdb_loc);
                if (exp_q.size() == 0) begin
                    check("unexpected_cdb", 64'(cdb_uid), 64'hFFFF_FFFF);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("cdb_pkt", {cdb_uid, cdb_val, cdb_loc, cdb_grant},
                          {e_mon.uid, e_mon.val, e_mon.loc, e_mon.grant});
                end
            end
            if (fu_valid != '0) begin
                check("protocol_valid_vs_ready", 64'(fu_valid & ~fu_ready), 64'd0);
            end
            prev_stall = cdb_valid && !cdb_ready;
            prev_out   = {cdb_uid, cdb_val, cdb_loc, cdb_grant, cdb_valid};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        fu_valid  = '0;
        fu_uid    = '0;
        fu_val    = '0;
        fu_loc    = '0;
        cdb_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_fu_ready", 64'(fu_ready), 64'd0);
        check("rst_cdb_out", {cdb_uid, cdb_val, cdb_loc, cdb_grant}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fu_ready", 64'(fu_ready), 64'hF);
        check("post_rst_cdb_valid", 64'(cdb_valid), 64'd0);

        // Single result on FU1: one cycle latency (zero with bypass)
        tick();
        cdb_ready = 1'b1;
        expect_pkt(1, 5, 16'h12AB, 18'h00040);
        issue(1, 5, 16'h12AB, 18'h00040);
        @(negedge clk);
        check("t1_same_cycle_valid", 64'(cdb_valid), 64'(BYP));
        tick();
        fu_valid = '0;
        @(negedge clk);
        check("t1_next_cycle_valid", 64'(cdb_valid), 64'(!BYP));
        // FU3 single result moves the pointer from 2 to 0 (wrap)
        tick();
        expect_pkt(3, 7, 16'h0003, 18'h3FFFF);
        issue(3, 7, 16'h0003, 18'h3FFFF);
        tick();
        fu_valid = '0;
        wait_drain("t1_drain");

        // All four FUs at once from pointer 0: grants 0,1,2,3
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_pkt(i, 10 + i, 16'h1000 * 16'(i + 1), 18'(i * 4096 + 1));
            issue(i, 10 + i, 16'h1000 * 16'(i + 1), 18'(i * 4096 + 1));
        end
        tick();
        fu_valid = '0;
        wait_drain("t2_drain");
        // Pointer back at 0: FU1 beats FU3
        tick();
        expect_pkt(1, 15, 16'hBEEF, 18'h00111);
        expect_pkt(3, 16, 16'hCAFE, 18'h00333);
        issue(1, 15, 16'hBEEF, 18'h00111);
        issue(3, 16, 16'hCAFE, 18'h00333);
        tick();
        fu_valid = '0;
        wait_drain("t2b_drain");
        tick();
        @(negedge clk);
        check("idle_cdb_valid", 64'(cdb_valid), 64'd0);
        check("idle_grant_hold", 64'(cdb_grant), 64'd3);

        // FU2 back-to-back under stall; FU0 must not preempt the held grant
        cdb_ready = 1'b0;
        expect_pkt(2, 20, 16'h2020, 18'h02000);
        expect_pkt(0, 30, 16'h3030, 18'h03000);
        expect_pkt(2, 21, 16'h2121, 18'h02001);
        expect_pkt(2, 22, 16'h2222, 18'h02002);
        tick();
        issue(2, 20, 16'h2020, 18'h02000);
        tick();
        fu_valid = '0;
        @(negedge clk);
        check("t3_ready_after_1", 64'(fu_ready[2]), 64'd1);
        check("t3_grant", 64'(cdb_grant), 64'd2);
        tick();
        issue(2, 21, 16'h2121, 18'h02001);
        issue(0, 30, 16'h3030, 18'h03000);
        tick();
        fu_valid = '0;
        @(negedge clk);
        check("t3_ready_after_2", 64'(fu_ready[2]), 64'd0);
        check("t3_hold_uid", 64'(cdb_uid), 64'd20);
        check("t3_hold_grant", 64'(cdb_grant), 64'd2);
        repeat (2) tick();
        cdb_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!fu_ready[2] && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("t3_ready_returns", 64'(fu_ready[2]), 64'd1);
        end
        issue(2, 22, 16'h2222, 18'h02002);
        tick();
        fu_valid = '0;
        wait_drain("t3_drain");

        // FU1 stream of 8 through a full buffer, pointers wrap
        cdb_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_pkt(1, 40 + k, 16'hA000 | 16'(k), 18'(256 + k));
        end
        stream(1, 8, 40, 4, -1);
        wait_drain("t4_drain");

        // Reset with 5 buffered packets: all discarded
        cdb_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            issue(i, 80 + i, 16'h8000 | 16'(i), 18'(i));
        end
        tick();
        fu_valid = '0;
        issue(0, 84, 16'h8004, 18'h00004);
        tick();
        fu_valid = '0;
        @(negedge clk);
        check("t5_pre_valid", 64'(cdb_valid), 64'd1);
        tick();
        rst       = 1'b1;
        cdb_ready = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", 64'(cdb_valid), 64'd0);
        check("t5_rst_ready", 64'(fu_ready), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_all", 64'(fu_ready), 64'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t5_no_stale", 64'(cdb_valid), 64'd0);
        end

        // Fairness: FU0 streams, FU3 valid once, FU3 second on the CDB
        cdb_ready = 1'b1;
        expect_pkt(0, 60, 16'hA000, 18'd0);
        expect_pkt(3, 50, 16'h0F03, 18'h00003);
        for (int k = 1; k < 6; k++) begin
            expect_pkt(0, 60 + k, 16'hA000 | 16'(k), 18'(k));
        end
        stream(0, 6, 60, 0, 1);
        wait_drain("t6_drain");
        tick();
        @(negedge clk);
        check("final_idle", 64'(cdb_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
